// File: rtl/dram_mbist_if.sv
// dram_mbist_if: write/read/address channel between the MBIST engine
// (master) and one port of the dual-port dram (slave).
interface dram_mbist_if #(
  parameter int WIDTH = 32,
  parameter int ADDR  = 5
);
  logic [ADDR-1:0]  mem_addr_o;
  logic             mem_wr_en_o;
  logic [WIDTH-1:0] mem_wr_data_o;
  logic             mem_rd_en_o;
  logic [WIDTH-1:0] mem_rd_data_i;

  modport master (
    output mem_addr_o,
    output mem_wr_en_o,
    output mem_wr_data_o,
    output mem_rd_en_o,
    input  mem_rd_data_i
  );

  modport slave (
    input  mem_addr_o,
    input  mem_wr_en_o,
    input  mem_wr_data_o,
    input  mem_rd_en_o,
    output mem_rd_data_i
  );
endinterface

// File: rtl/dram_mbist.sv
// dram_mbist: March C- self-test engine for one dram port.
// Ports: clk_i/rstn_i, start_i, busy_o/done_o/fail_o, err_addr_o,
// err_cnt_o (saturating), mem (dram_mbist_if.master channel).
// Option: DRAM_MBIST_STOP_ON_FAIL_EN ends the run on the first mismatch.
module dram_mbist #(
  parameter int          WIDTH   = 32,
  parameter int          DEPTH   = 32,
  parameter int          ADDR    = $clog2(DEPTH),
  parameter int          RD_LAT  = 1,
  parameter logic [31:0] PATTERN = 32'h5555_5555,
  parameter int          CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             fail_o,
  output logic [ADDR-1:0]  err_addr_o,
  output logic [CNT_W-1:0] err_cnt_o,
  dram_mbist_if.master     mem
);

  typedef enum logic [3:0] {
    IDLE, E0, E1, E2, E3, E4, E5, DRAIN, DONE
  } state_e;

  localparam logic [WIDTH-1:0] P0 = WIDTH'(PATTERN);
  localparam logic [WIDTH-1:0] P1 = ~P0;
  localparam logic [ADDR-1:0]  LAST = ADDR'(DEPTH - 1);
  localparam logic [2:0]       DRN_LAST = 3'(RD_LAT - 1);

  state_e           state_q, state_d;
  logic [ADDR-1:0]  addr_q, addr_d;
  // 0: read half, 1: write half of an E1..E4 address
  logic             ph_q, ph_d;
  logic [2:0]       drn_q, drn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic [ADDR-1:0]  eaddr_q, eaddr_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic [ADDR-1:0]  maddr_q, maddr_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [WIDTH-1:0] pe_q [RD_LAT];
  logic [WIDTH-1:0] pe_d [RD_LAT];
  logic [ADDR-1:0]  pa_q [RD_LAT];
  logic [ADDR-1:0]  pa_d [RD_LAT];
  logic             accept;
  logic             mis;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ph_d    = ph_q;
    drn_d   = drn_q;
    accept  = 1'b0;
    mis     = pv_q[RD_LAT-1] &&
              (mem.mem_rd_data_i != pe_q[RD_LAT-1]);

    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = E0;
          addr_d  = '0;
          ph_d    = 1'b0;
        end
      end
      E0: begin
        if (addr_q == LAST) begin
          state_d = E1;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      E1, E2: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          if (addr_q == LAST) begin
            state_d = (state_q == E1) ? E2 : E3;
            addr_d  = (state_q == E1) ? '0 : LAST;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      E3, E4: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          if (addr_q == '0) begin
            state_d = (state_q == E3) ? E4 : E5;
            addr_d  = LAST;
          end else begin
            addr_d = addr_q - 1'b1;
          end
        end
      end
      E5: begin
        if (addr_q == '0) begin
          state_d = DRAIN;
          drn_d   = '0;
        end else begin
          addr_d = addr_q - 1'b1;
        end
      end
      DRAIN: begin
        if (drn_q == DRN_LAST) begin
          state_d = DONE;
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef DRAM_MBIST_STOP_ON_FAIL_EN
    if (mis) begin
      state_d = DONE;
    end
`endif

    // Outputs are registered, so decode the access of the next cycle.
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    wdata_d = '0;
    exp_d   = '0;
    maddr_d = '0;
    unique case (state_d)
      E0: begin
        wr_d    = 1'b1;
        wdata_d = P0;
      end
      E1, E3: begin
        wr_d    = ph_d;
        rd_d    = ~ph_d;
        wdata_d = ph_d ? P1 : '0;
        exp_d   = ph_d ? '0 : P0;
      end
      E2, E4: begin
        wr_d    = ph_d;
        rd_d    = ~ph_d;
        wdata_d = ph_d ? P0 : '0;
        exp_d   = ph_d ? '0 : P1;
      end
      E5: begin
        rd_d  = 1'b1;
        exp_d = P0;
      end
      default: ;
    endcase
    if (wr_d || rd_d) begin
      maddr_d = addr_d;
    end

    busy_d = state_d inside {E0, E1, E2, E3, E4, E5, DRAIN};
    done_d = (state_d == DONE);

    fail_d  = fail_q;
    eaddr_d = eaddr_q;
    ecnt_d  = ecnt_q;
    if (accept) begin
      fail_d  = 1'b0;
      eaddr_d = '0;
      ecnt_d  = '0;
    end else if (mis) begin
      fail_d = 1'b1;
      if (!fail_q) begin
        eaddr_d = pa_q[RD_LAT-1];
      end
      if (ecnt_q != '1) begin
        ecnt_d = ecnt_q + 1'b1;
      end
    end

    // Delay line tracks each issued read until its data returns.
    pv_d    = pv_q;
    pe_d    = pe_q;
    pa_d    = pa_q;
    pv_d[0] = rd_q;
    pe_d[0] = exp_q;
    pa_d[0] = maddr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
      pa_d[i] = pa_q[i-1];
    end
`ifdef DRAM_MBIST_STOP_ON_FAIL_EN
    if (mis) begin
      pv_d = '0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ph_q    <= 1'b0;
      drn_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      eaddr_q <= '0;
      ecnt_q  <= '0;
      maddr_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      wdata_q <= '0;
      exp_q   <= '0;
      pv_q    <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pe_q[i] <= '0;
        pa_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ph_q    <= ph_d;
      drn_q   <= drn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      eaddr_q <= eaddr_d;
      ecnt_q  <= ecnt_d;
      maddr_q <= maddr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      exp_q   <= exp_d;
      pv_q    <= pv_d;
      pe_q    <= pe_d;
      pa_q    <= pa_d;
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign fail_o            = fail_q;
  assign err_addr_o        = eaddr_q;
  assign err_cnt_o         = ecnt_q;
  assign mem.mem_addr_o    = maddr_q;
  assign mem.mem_wr_en_o   = wr_q;
  assign mem.mem_wr_data_o = wdata_q;
  assign mem.mem_rd_en_o   = rd_q;

endmodule

// File: tb/tb_dram_mbist.sv
// tb_dram_mbist: two engines (RD_LAT 1 and 3) on behavioural drams
// with a stuck-bit fault, checked against a March C- reference model.
module tb_dram_mbist;

  localparam int W = 32;
  localparam int D = 8;
  localparam int A = 3;
  localparam logic [W-1:0] P0 = 32'h5555_5555;
  localparam logic [W-1:0] P1 = 32'hAAAA_AAAA;
`ifdef DRAM_MBIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic         busy0, done0, fail0;
  logic [A-1:0] eaddr0;
  logic [15:0]  ecnt0;
  logic         busy1, done1, fail1;
  logic [A-1:0] eaddr1;
  logic [15:0]  ecnt1;

  dram_mbist_if #(.WIDTH(W), .ADDR(A)) if0 ();
  dram_mbist_if #(.WIDTH(W), .ADDR(A)) if1 ();

  dram_mbist #(.WIDTH(W), .DEPTH(D), .RD_LAT(1)) u0 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start),
    .busy_o(busy0), .done_o(done0), .fail_o(fail0),
    .err_addr_o(eaddr0), .err_cnt_o(ecnt0), .mem(if0)
  );

  dram_mbist #(.WIDTH(W), .DEPTH(D), .RD_LAT(3)) u1 (
    .clk_i(clk), .rstn_i(rstn), .start_i(start),
    .busy_o(busy1), .done_o(done1), .fail_o(fail1),
    .err_addr_o(eaddr1), .err_cnt_o(ecnt1), .mem(if1)
  );

  bit f_en;
  int f_addr;
  int f_bit;
  bit f_val;

  function automatic logic [W-1:0] stuck(input logic [W-1:0] d,
                                         input int a);
    logic [W-1:0] r;
    r = d;
    if (f_en && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  logic [W-1:0] mem0 [D];
  logic [W-1:0] mem1 [D];
  logic [W-1:0] rp0;
  logic [W-1:0] rp1 [3];

  always @(posedge clk) begin
    if (if0.mem_wr_en_o) mem0[if0.mem_addr_o] <= if0.mem_wr_data_o;
    rp0 <= if0.mem_rd_en_o ?
           stuck(mem0[if0.mem_addr_o], int'(if0.mem_addr_o)) : '0;
    if (if1.mem_wr_en_o) mem1[if1.mem_addr_o] <= if1.mem_wr_data_o;
    rp1[0] <= if1.mem_rd_en_o ?
              stuck(mem1[if1.mem_addr_o], int'(if1.mem_addr_o)) : '0;
    rp1[1] <= rp1[0];
    rp1[2] <= rp1[1];
  end
  assign if0.mem_rd_data_i = rp0;
  assign if1.mem_rd_data_i = rp1[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           c;
    bit           w;
    bit           r;
    logic [A-1:0] a;
    logic [W-1:0] d;
  } op_t;

  op_t obs_q[$];
  op_t ref_q[$];
  bit  mon_en = 1'b0;
  int  drv_bad, busy_n0, busy_n1;

  always @(negedge clk) begin : mon
    op_t o;
    if (mon_en) begin
      if (if0.mem_wr_en_o && if0.mem_rd_en_o) drv_bad++;
      if (if1.mem_wr_en_o && if1.mem_rd_en_o) drv_bad++;
      if (!if0.mem_wr_en_o && !if0.mem_rd_en_o &&
          (if0.mem_addr_o != 0 || if0.mem_wr_data_o != 0)) drv_bad++;
      if (!if1.mem_wr_en_o && !if1.mem_rd_en_o &&
          (if1.mem_addr_o != 0 || if1.mem_wr_data_o != 0)) drv_bad++;
      if (if0.mem_wr_en_o || if0.mem_rd_en_o) begin
        o.c = cyc;
        o.w = if0.mem_wr_en_o;
        o.r = if0.mem_rd_en_o;
        o.a = if0.mem_addr_o;
        o.d = if0.mem_wr_en_o ? if0.mem_wr_data_o : '0;
        obs_q.push_back(o);
      end
      busy_n0 += int'(busy0);
      busy_n1 += int'(busy1);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: March C- as a list of accesses plus an array memory.
  int m_cnt, m_addr, m_first;

  task automatic model();
    logic [W-1:0] mm [D];
    int c;
    op_t o;
    c = 0;
    ref_q.delete();
    m_cnt = 0;
    m_addr = 0;
    m_first = -1;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < D; k++) begin
        int a;
        a = (e < 3) ? k : D - 1 - k;
        if (e > 0) begin
          logic [W-1:0] bg;
          bg = (e == 2 || e == 4) ? P1 : P0;
          o.c = c; o.w = 0; o.r = 1; o.a = A'(a); o.d = '0;
          ref_q.push_back(o);
          if (stuck(mm[a], a) !== bg) begin
            if (m_cnt == 0) begin
              m_addr = a;
              m_first = c;
            end
            m_cnt++;
          end
          c++;
        end
        if (e < 5) begin
          logic [W-1:0] bg;
          bg = (e == 1 || e == 3) ? P1 : P0;
          mm[a] = bg;
          o.c = c; o.w = 1; o.r = 0; o.a = A'(a); o.d = bg;
          ref_q.push_back(o);
          c++;
        end
      end
    end
  endtask

  task automatic set_fault(input bit en, input int a, input int b,
                           input bit v);
    f_en = en;
    f_addr = a;
    f_bit = b;
    f_val = v;
  endtask

  int t0, d0, d1;

  task automatic kick(input bit hold);
    obs_q.delete();
    drv_bad = 0;
    busy_n0 = 0;
    busy_n1 = 0;
    mon_en = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    d0 = -1;
    d1 = -1;
    for (int i = 0; i < budget && (d0 < 0 || d1 < 0); i++) begin
      @(negedge clk);
      if (done0 && d0 < 0) d0 = cyc - t0;
      if (done1 && d1 < 0) d1 = cyc - t0;
    end
    mon_en = 1'b0;
  endtask

  function automatic logic [63:0] pk(input op_t o, input int base);
    return {6'd0, 16'(o.c - base), o.w, o.r, 8'(o.a), o.d};
  endfunction

  task automatic check_run(input string tag);
    int lat0, lat1, ncnt, lim, nexp, n;
    bit stopped;
    stopped = STOP && m_first >= 0;
    lat0 = stopped ? m_first + 2 : 10 * D + 1;
    lat1 = stopped ? m_first + 4 : 10 * D + 3;
    lim  = stopped ? m_first + 1 : 1 << 20;
    ncnt = STOP ? int'(m_cnt > 0) : m_cnt;
    chk({tag, ".lat0"}, d0, lat0);
    chk({tag, ".lat1"}, d1, lat1);
    chk({tag, ".busy0"}, busy_n0, lat0);
    chk({tag, ".busy1"}, busy_n1, lat1);
    chk({tag, ".fail0"}, fail0, m_cnt > 0);
    chk({tag, ".fail1"}, fail1, m_cnt > 0);
    chk({tag, ".cnt0"}, ecnt0, ncnt);
    chk({tag, ".cnt1"}, ecnt1, ncnt);
    chk({tag, ".addr0"}, eaddr0, m_addr);
    chk({tag, ".addr1"}, eaddr1, m_addr);
    chk({tag, ".drv"}, drv_bad, 0);
    nexp = 0;
    foreach (ref_q[i]) if (ref_q[i].c <= lim) nexp++;
    chk({tag, ".nops"}, obs_q.size(), nexp);
    n = (obs_q.size() < nexp) ? obs_q.size() : nexp;
    for (int i = 0; i < n; i++) begin
      chk({tag, ".op"}, pk(obs_q[i], t0), pk(ref_q[i], 0));
    end
  endtask

  function automatic logic [63:0] outs0();
    return {5'd0, busy0, done0, fail0, eaddr0, ecnt0,
            if0.mem_wr_en_o, if0.mem_rd_en_o,
            if0.mem_addr_o, if0.mem_wr_data_o};
  endfunction

  function automatic logic [63:0] outs1();
    return {5'd0, busy1, done1, fail1, eaddr1, ecnt1,
            if1.mem_wr_en_o, if1.mem_rd_en_o,
            if1.mem_addr_o, if1.mem_wr_data_o};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    set_fault(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst.u0", outs0(), 0);
    chk("rst.u1", outs1(), 0);
    rstn = 1'b1;

    model();
    kick(0);
    wait_done(300);
    check_run("clean");

    set_fault(1, 5, 0, 1);
    model();
    kick(0);
    wait_done(300);
    check_run("sa1");
    chk("sa1.spec_cnt", ecnt0, STOP ? 1 : 2);
    chk("sa1.spec_addr", eaddr0, 5);
    chk("sa1.spec_lat", d0, STOP ? 36 : 81);

    repeat (6) begin
      set_fault(1, $urandom_range(0, D - 1), $urandom_range(0, W - 1),
                1'($urandom_range(0, 1)));
      model();
      kick(0);
      wait_done(300);
      check_run("rand");
    end

    set_fault(1, 5, 0, 1);
    kick(0);
    repeat ($urandom_range(40, 55)) @(negedge clk);
    rstn = 1'b0;
    mon_en = 1'b0;
    @(negedge clk);
    chk("midrst.u0", outs0(), 0);
    chk("midrst.u1", outs1(), 0);
    @(negedge clk);
    rstn = 1'b1;
    set_fault(0, 0, 0, 0);
    model();
    kick(0);
    wait_done(300);
    check_run("postrst");

    kick(1);
    d0 = -1;
    for (int i = 0; i < 300 && d0 < 0; i++) begin
      @(negedge clk);
      if (done0) d0 = cyc - t0;
    end
    mon_en = 1'b0;
    chk("hold.lat", d0, 81);
    @(negedge clk);
    chk("hold.restart", {done0, busy0}, 2'b01);
    t0 = cyc;
    start = 1'b0;
    wait_done(300);
    chk("hold.lat2", d0, 81);
    chk("hold.fail", fail0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dram_mbist.md
# dram_mbist

March-style memory built-in self-test engine that initiates accesses on one port of the dual-port `dram` and checks the returned read data. It drives the write/read/address channel that the RAM responds to, so the same port map plugs straight onto `pa_*` or `pb_*`. Software pulses `start_i`; the block walks every address with a March C- sequence and reports pass/fail, first failing address and error count.

## Interface

**Parameters**
- `WIDTH`, 32: data width; must match the attached `dram`.
- `DEPTH`, 32: number of words tested; must be ≥ 2.
- `ADDR`, `$clog2(DEPTH)`: address width.
- `RD_LAT`, 1: `dram` read latency in cycles, from `mem_rd_en_o` to valid `mem_rd_data_i`; range 1..4.
- `PATTERN`, 32'h5555_5555: background "0" word, truncated to `WIDTH`. Background "1" is `~PATTERN`.
- `CNT_W`, 16: width of the error counter.

**Ports**
- `clk_i`, input, 1: clock; the same clock as the attached `dram` port.
- `rstn_i`, input, 1: asynchronous active-low reset.
- `start_i`, input, 1: level-sampled start request.
- `busy_o`, output, 1: test in progress.
- `done_o`, output, 1: test finished. Held high until the next accepted start.
- `fail_o`, output, 1: sticky mismatch flag for the current or last run.
- `err_addr_o`, output, ADDR: address of the first mismatch.
- `err_cnt_o`, output, CNT_W: mismatch count. Saturates at all-ones.
- `mem_addr_o`, output, ADDR: address to `dram`.
- `mem_wr_en_o`, output, 1: write strobe to `dram`.
- `mem_wr_data_o`, output, WIDTH: write data to `dram`.
- `mem_rd_en_o`, output, 1: read strobe to `dram`.
- `mem_rd_data_i`, input, WIDTH: read data from `dram`.

## Operation

- **States:** IDLE, E0..E5, DRAIN, DONE.
- **IDLE/DONE → E0:** taken when `start_i`=1. On this transition `fail_o`, `err_cnt_o`, `err_addr_o` and `done_o` clear. `start_i` is ignored in E0..DRAIN.
- **E0 (up):** write P to each address. 1 cycle per address.
- **E1 (up):** read, expect P; then write ~P.
- **E2 (up):** read, expect ~P; then write P.
- **E3 (down):** read, expect P; then write ~P.
- **E4 (down):** read, expect ~P; then write P.
- **E5 (down):** read, expect P. 1 cycle per address.
- **Per-address cycles in E1..E4:** 2 cycles per address. The read cycle comes first, the write cycle second, and both use the same address.
- **Address sequencing:** up elements run 0→DEPTH-1; down elements run DEPTH-1→0. An element moves to the next element in the cycle after its final address. There is no wrap.
- **After E5:** → DRAIN for RD_LAT cycles → DONE.
- **Check pipeline:** each read pushes {expected, addr} into an RD_LAT-deep delay line. When the entry emerges, `mem_rd_data_i` is compared with the expected word. On mismatch:
  - `fail_o`←1;
  - `err_cnt_o`+1, saturating;
  - `err_addr_o` is loaded only if this is the first mismatch of the run.
- **Driving rule:** `mem_wr_en_o` and `mem_rd_en_o` are never high in the same cycle. When neither is active, `mem_addr_o` and `mem_wr_data_o` are 0.
- **Reset:** valid at any time, including mid-run. All outputs go to 0, the state returns to IDLE and the delay line is flushed.

## Timing

- All outputs are registered.
- **Start:** `start_i` sampled high at edge N → from edge N:
  - `busy_o`=1;
  - first write is presented: `mem_addr_o`=0, `mem_wr_data_o`=P, `mem_wr_en_o`=1.
- **Access count:** total issue cycles = 10·DEPTH.
- **Completion:** the last read is issued at cycle N+10·DEPTH-1. Its compare happens RD_LAT cycles later. At the following edge `busy_o`→0 and `done_o`→1.
- **Total:** start-to-done = 10·DEPTH + RD_LAT cycles.
- **Flag update:** `fail_o` rises at the edge after the mismatching data is sampled.

## Configuration

- **`DRAM_MBIST_STOP_ON_FAIL_EN` defined:** the first mismatch ends the run. On the next edge the block goes to DONE with `busy_o`=0, `done_o`=1, `err_cnt_o`=1. Memory strobes stop immediately, and reads still in the delay line are discarded.
- **Not defined:** the full sequence always runs. `err_cnt_o` counts every mismatch.

## Test plan

All scenarios use `DEPTH`=8, `RD_LAT`=1, `WIDTH`=32, `PATTERN`=32'h5555_5555.

1. **Fault-free run.** Attach an ideal `dram`, reset, pulse `start_i` → `busy_o` high for 81 cycles, then `done_o`=1, `fail_o`=0, `err_cnt_o`=0. Trace checks:
   - 8 writes of 5555_5555 in E0;
   - addresses ascend 0..7 in E1..E2;
   - addresses descend 7..0 in E3..E5;
   - no cycle has both strobes high.
2. **Stuck-at-1, macro undefined.** Bit 0 of address 5 reads as 1 → `fail_o`=1, `err_addr_o`=5, `err_cnt_o`=2 (mismatches at the ~P reads in E2 and E4).
3. **Stuck-at-1, macro defined.** Same fault as scenario 2 → run stops 1 cycle after the E2 read of address 5. `err_cnt_o`=1 and no further strobes occur.
4. **Reset mid-run.** Assert `rstn_i`=0 during E3 → all outputs read 0 while reset is held, state returns to IDLE. A new start then completes clean as in scenario 1.
5. **Start while busy.** Hold `start_i` high for the whole run → run length is still 81 cycles. After `done_o`, the held level immediately restarts the test and clears `done_o`.
6. **Latency sweep.** Repeat scenario 1 with `RD_LAT`=3 and a 3-cycle memory model → done at 83 cycles, `fail_o`=0.
